// File: rtl/soma_chave_rodada_pkg.sv
// Shared decryption definitions: datapath widths, default round count and
// the split of a key-store word address into round slot and word position.
package soma_chave_rodada_pkg;

   localparam int LARGURA_BLOCO      = 128;
   localparam int LARGURA_PALAVRA    = 32;
   localparam int NUM_RODADAS_PADRAO = 10;

   // Word address layout: upper bits select the round slot, lower two bits
   // select the 32-bit word inside it (word 0 is the most significant).
   typedef struct packed {
      logic [3:0] slot;
      logic [1:0] palavra;
   } endereco_t;

   function automatic endereco_t divide_endereco(input logic [5:0] endereco);
      endereco_t partes;
      partes.slot    = endereco[5:2];
      partes.palavra = endereco[1:0];
      return partes;
   endfunction

endpackage

// File: rtl/memoria_chaves_rodada.sv
// Round-key store: one 32-bit write port, one 128-bit asynchronous read port
// indexed by round slot. Writes beyond the last slot are dropped.
module memoria_chaves_rodada
   import soma_chave_rodada_pkg::*;
#(
   parameter int NUM_RODADAS = NUM_RODADAS_PADRAO
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       we,
   input  logic [5:0]                 endereco,
   input  logic [LARGURA_PALAVRA-1:0] dado,
   input  logic [3:0]                 slot,
   output logic [LARGURA_BLOCO-1:0]   chave
);

   localparam logic [6:0] NUM_PALAVRAS = 7'(4 * (NUM_RODADAS + 1));
   localparam logic [4:0] ULTIMO_SLOT  = 5'(NUM_RODADAS);

   logic [LARGURA_BLOCO-1:0] chaves [0:NUM_RODADAS];
   endereco_t                partes;
   logic                     escrita_valida;

   assign partes         = divide_endereco(endereco);
   assign escrita_valida = we & ({1'b0, endereco} < NUM_PALAVRAS);

   // Key words: cleared on reset, otherwise updated one word per write.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i <= NUM_RODADAS; i++) begin
            chaves[i] <= {LARGURA_BLOCO{1'b0}};
         end
      end else if (escrita_valida) begin
         case (partes.palavra)
            2'd0:    chaves[partes.slot][127:96] <= dado;
            2'd1:    chaves[partes.slot][95:64]  <= dado;
            2'd2:    chaves[partes.slot][63:32]  <= dado;
            2'd3:    chaves[partes.slot][31:0]   <= dado;
            default: chaves[partes.slot]         <= chaves[partes.slot];
         endcase
      end
   end

   // Asynchronous read; a slot outside the store reads as zero.
   always_comb begin
      chave = {LARGURA_BLOCO{1'b0}};
      if ({1'b0, slot} <= ULTIMO_SLOT) begin
         chave = chaves[slot];
      end else begin
         chave = {LARGURA_BLOCO{1'b0}};
      end
   end

endmodule

// File: rtl/soma_chave_rodada.sv
// AddRoundKey stage of the decryption datapath. Walks round keys from
// NUM_RODADAS down to 0 and hands results downstream through a one-entry
// valid/ready output register.
module soma_chave_rodada
   import soma_chave_rodada_pkg::*;
#(
   parameter int NUM_RODADAS = NUM_RODADAS_PADRAO
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       chave_we,
   input  logic [5:0]                 chave_endereco,
   input  logic [LARGURA_PALAVRA-1:0] chave_dado,
   input  logic                       inicio,
   input  logic                       entrada_valida,
   output logic                       entrada_pronta,
   input  logic [LARGURA_BLOCO-1:0]   bloco,
   output logic                       saida_valida,
   input  logic                       saida_pronta,
   output logic [LARGURA_BLOCO-1:0]   saida,
   output logic [3:0]                 rodada,
   output logic                       ultima
);

   localparam logic [3:0] RODADA_INICIAL = 4'(NUM_RODADAS);

   logic [3:0]               ptr;
   logic [3:0]               indice;
   logic [LARGURA_BLOCO-1:0] chave;
   logic                     aceite;
   logic                     dreno;

   // The slot is free when empty or being drained this cycle.
   assign entrada_pronta = !saida_valida | saida_pronta;
   assign aceite         = entrada_valida & entrada_pronta;
   assign dreno          = saida_valida & saida_pronta;

   // A new block always restarts from the highest round key.
   always_comb begin
      indice = ptr;
      if (inicio) begin
         indice = RODADA_INICIAL;
      end else begin
         indice = ptr;
      end
   end

   // Asynchronous read sees the pre-write key, so a same-cycle write to the
   // slot in use only takes effect for later blocks.
   memoria_chaves_rodada #(
      .NUM_RODADAS (NUM_RODADAS)
   ) u_memoria (
      .clock    (clock),
      .reset    (reset),
      .we       (chave_we),
      .endereco (chave_endereco),
      .dado     (chave_dado),
      .slot     (indice),
      .chave    (chave)
   );

   // Round pointer advances only on accepted blocks and wraps after round 0.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ptr <= RODADA_INICIAL;
      end else if (aceite) begin
         ptr <= (indice == 4'd0) ? RODADA_INICIAL : indice - 4'd1;
      end
   end

   // Output register: load on accept, empty on drain, hold otherwise.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         saida_valida <= 1'b0;
         saida        <= {LARGURA_BLOCO{1'b0}};
         rodada       <= 4'd0;
         ultima       <= 1'b0;
      end else if (aceite) begin
         saida_valida <= 1'b1;
         saida        <= bloco ^ chave;
         rodada       <= indice;
         ultima       <= (indice == 4'd0);
      end else if (dreno) begin
         saida_valida <= 1'b0;
      end
   end

endmodule

// File: doc/soma_chave_rodada.md
# soma_chave_rodada

Registered AddRoundKey stage of the decryption datapath, sitting directly upstream of the inverse column-mix stage. It XORs each 128-bit state block with the round key for the current round. It walks the round keys in decryption order, from round NUM_RODADAS down to 0. It owns the round-key store, which is loaded one 32-bit word at a time, and decouples producer and consumer through a one-entry valid/ready output register.

## Interface
- NUM_RODADAS, 10: number of cipher rounds; the key store holds NUM_RODADAS+1 round keys (4·(NUM_RODADAS+1) words).
- clock  input  1  sole clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- chave_we  input  1  round-key word write enable.
- chave_endereco  input  6  word address; slot = addr/4, word = addr%4 (word 0 = bits [127:96]).
- chave_dado  input  32  round-key word data.
- inicio  input  1  sampled with an accepted block; forces use of key slot NUM_RODADAS (start of a new block decryption).
- entrada_valida  input  1  upstream block valid.
- entrada_pronta  output  1  stage can accept a block.
- bloco  input  128  input state block.
- saida_valida  output  1  output register holds a block.
- saida_pronta  input  1  downstream (column-mix stage) accepts.
- saida  output  128  bloco XOR round key.
- rodada  output  4  round index of the key applied to saida.
- ultima  output  1  high when rodada == 0 (final AddRoundKey of the block).

## Operation
- Accept = entrada_valida & entrada_pronta. Drain = saida_valida & saida_pronta.
- entrada_pronta = !saida_valida | saida_pronta (combinational; accept and drain may occur in the same cycle).
- Round pointer ptr, 4 bits, reset value NUM_RODADAS. Index used on accept: NUM_RODADAS if inicio, else ptr.
- On accept: saida <= bloco ^ key[index]; rodada <= index; ultima <= (index == 0); saida_valida <= 1; ptr <= (index == 0) ? NUM_RODADAS : index − 1.
- On drain without accept: saida_valida <= 0; saida, rodada and ultima hold.
- Key write: if chave_we and addr < 4·(NUM_RODADAS+1), the addressed 32-bit word is updated; otherwise the write is silently ignored.
- A key write to the slot being read in the same cycle does not affect that XOR; the old key is used and the new word is visible from the next cycle.
- inicio without accept has no effect on ptr.

## Timing
- Latency: 1 cycle from accept to saida_valida and saida.
- Throughput: 1 block/cycle while saida_pronta = 1.
- Backpressure: while saida_valida & !saida_pronta, saida, rodada and ultima are stable and entrada_pronta = 0.
- Reset, including mid-operation: saida_valida = 0, saida = 0, rodada = 0, ultima = 0, ptr = NUM_RODADAS, all key words = 0. Any in-flight block is discarded.
- No dedicated FSM; state is ptr plus the output register (EMPTY ⇄ FULL by saida_valida).

## Structure
- Shared decryption package holds:
  - block width 128
  - key word width 32
  - NUM_RODADAS default
  - the address-to-slot/word split helper
- One natural sub-module, memoria_chaves_rodada: key store with a 32-bit write port and a 128-bit asynchronous read port indexed by slot.
- The XOR and handshake logic stay in the top module.

## Test plan
- Key slot 10 = 128'h0, bloco = 128'h200a0157414a0b253c1d1052414c1d3e with inicio = 1 → next cycle saida = same value, rodada = 10, ultima = 0.
- Key slot 10 = all-F words, bloco = 128'h0, inicio = 1 → saida = 128'hFFFF…FFFF; the next accept without inicio uses slot 9.
- Eleven back-to-back accepts (first with inicio) and saida_pronta = 1 → rodada sequence 10,9,…,0; ultima only on the 11th; a 12th accept without inicio gives rodada = 10.
- Hold saida_pronta = 0 for 5 cycles with entrada_valida = 1 → saida, rodada and ultima frozen, entrada_pronta = 0, exactly one block accepted. Releasing saida_pronta gives accept and drain in the same cycle.
- Write chave_endereco = 44 (out of range) with data 32'hDEADBEEF → all key slots unchanged. Write address 40 and accept with slot 10 in the same cycle → old key used; the next inicio block sees the new word in bits [127:96].
- Assert reset while saida_valida = 1 and ptr = 4 → outputs are 0 immediately; after release the next accept uses slot 10, and slots read back as 0.
